vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal and vertical pixel counters, blanking, sync, display-enable, line-start, frame-start and a frame counter. It supports two compile-time video modes (A and B) that can be selected at runtime, and a pixel-enable input for clock-divided pipelines. It sits at the head of the video pipeline and feeds every downstream draw/overlay stage.

## Interface
Parameters:
- CW, 11, width of hcount/vcount
- FCW, 16, width of frame counter
- A_H_ACT / A_H_FP / A_H_SYNC / A_H_BP, 800 / 40 / 128 / 88, mode A horizontal segments (total 1056)
- A_V_ACT / A_V_FP / A_V_SYNC / A_V_BP, 600 / 1 / 4 / 23, mode A vertical segments (total 628)
- A_HS_POL / A_VS_POL, 1 / 1, mode A sync polarity (1 = active-high)
- B_H_ACT / B_H_FP / B_H_SYNC / B_H_BP, 640 / 16 / 96 / 48, mode B horizontal (total 800)
- B_V_ACT / B_V_FP / B_V_SYNC / B_V_BP, 480 / 10 / 2 / 33, mode B vertical (total 525)
- B_HS_POL / B_VS_POL, 0 / 0, mode B sync polarity

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; counters advance only when high
- mode_sel  in  1  requested mode (0 = A, 1 = B), pclk domain
- hcount  out  CW  current pixel column
- vcount  out  CW  current line
- hblnk  out  1  horizontal blank
- vblnk  out  1  vertical blank
- hsync  out  1  horizontal sync, polarity per active mode
- vsync  out  1  vertical sync, polarity per active mode
- de  out  1  display enable = !hblnk & !vblnk
- line_start  out  1  single-cycle strobe, first pixel of each line
- frame_start  out  1  single-cycle strobe, pixel (0,0) of each frame
- mode_act  out  1  mode currently in effect
- frame_cnt  out  FCW  completed-frame counter, wraps at 2^FCW

## Operation
- H_TOT = H_ACT+H_FP+H_SYNC+H_BP and V_TOT are taken from the active mode (mode_act).
- hcount runs 0..H_TOT-1. At H_TOT-1 it wraps to 0 and vcount increments. vcount runs 0..V_TOT-1 and wraps to 0 at (H_TOT-1, V_TOT-1).
- All outputs are registered and consistent with the hcount/vcount shown in the same cycle:
  - hblnk = hcount >= H_ACT
  - hsync active when H_ACT+H_FP <= hcount <= H_ACT+H_FP+H_SYNC-1
  - vblnk = vcount >= V_ACT
  - vsync active when V_ACT+V_FP <= vcount <= V_ACT+V_FP+V_SYNC-1
  - Active level = POL; inactive level = !POL.
- Mode switch: mode_sel is sampled only on the frame wrap (the ce-qualified cycle leaving (H_TOT-1, V_TOT-1)).
  - mode_act updates in the same cycle the counters show (0,0).
  - A mode_sel change mid-frame has no effect until the next frame boundary.
  - Sync polarity changes at the same instant.
- frame_cnt increments on each frame wrap.
- ce low: all registers hold and strobes are 0.
- line_start = 1 when a ce-qualified hcount wrap lands on hcount = 0; frame_start = 1 when additionally vcount = 0.
- Strobes are deasserted on the next pclk cycle regardless of ce.
- No strobe is issued on reset release. The first frame_start comes after the first full frame.

## Timing
- Reset (async, rst = 0):
  - hcount = 0, vcount = 0, frame_cnt = 0, mode_act = 0
  - hblnk = 0, vblnk = 0, de = 1, line_start = 0, frame_start = 0
  - hsync = !A_HS_POL, vsync = !A_VS_POL
- Reset asserted mid-frame forces these values immediately. Counting restarts at (0,0) on the first ce-qualified pclk edge after release, which advances to (1,0).
- Latency: exactly one pclk edge (with ce = 1) per pixel. Outputs change only on pclk rising edges.
- Mode A frame period = 1056 × 628 = 663168 enabled cycles. Mode B frame period = 800 × 525 = 420000.
- Counter widths: CW must hold max(H_TOT, V_TOT) - 1. Comparisons are unsigned. No overflow beyond the wrap.
- Simultaneous events: a frame wrap coinciding with a mode_sel change uses the new mode's totals starting from (0,0). frame_cnt wrap from 2^FCW-1 goes to 0 silently.

## Test plan
- Reset check: hold rst = 0 -> all outputs at reset values; hsync = vsync = 0 in mode A. Release with ce = 1 -> after 1 edge hcount = 1, vcount = 0.
- Mode A full frame: ce = 1 for 663168 cycles ->
  - hsync high for hcount 840..967 (128 cycles per line)
  - hblnk high for 800..1055
  - vsync high for lines 601..604
  - vblnk high for lines 600..627
  - exactly one frame_start at return to (0,0); frame_cnt = 1
- ce gating: ce toggling 1/0 every cycle for two lines -> counts advance on ce cycles only, 2 × 1056 enabled cycles per two lines, strobes one cycle wide.
- Mode switch mid-frame: set mode_sel = 1 at (100,300) -> mode_act stays 0 to frame end. Next frame then runs with:
  - H_TOT = 800, V_TOT = 525
  - hsync low for hcount 656..751
  - vsync low for lines 490..491
  - frame period 420000
- Reset mid-frame: assert rst at (500,400) for 3 cycles -> immediate reset values, no spurious frame_start, normal frame restarts at (0,0).
- Wrap corner: preload FCW = 2 and run 4 frames -> frame_cnt sequence 1, 2, 3, 0.

Source files
------------

// File: rtl/vga_timing_if.sv
// ============================================================================
// Module : vga_timing_if
// Brief  : Raster timing bundle between the timing generator and the video
//          pipeline stages that consume it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_timing_if #(
  parameter int CW  = 11,
  parameter int FCW = 16
);
  logic           ce;
  logic           mode_sel;
  logic [CW-1:0]  hcount;
  logic [CW-1:0]  vcount;
  logic           hblnk;
  logic           vblnk;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic           line_start;
  logic           frame_start;
  logic           mode_act;
  logic [FCW-1:0] frame_cnt;

  modport master (
    input  ce, mode_sel,
    output hcount, vcount, hblnk, vblnk, hsync, vsync, de,
           line_start, frame_start, mode_act, frame_cnt
  );

  modport slave (
    output ce, mode_sel,
    input  hcount, vcount, hblnk, vblnk, hsync, vsync, de,
           line_start, frame_start, mode_act, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : Two-mode VGA raster timing generator with pixel enable, registered
//          blank/sync/de, line/frame strobes and a completed-frame counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int FCW      = 16,
  parameter int A_H_ACT  = 800,
  parameter int A_H_FP   = 40,
  parameter int A_H_SYNC = 128,
  parameter int A_H_BP   = 88,
  parameter int A_V_ACT  = 600,
  parameter int A_V_FP   = 1,
  parameter int A_V_SYNC = 4,
  parameter int A_V_BP   = 23,
  parameter int A_HS_POL = 1,
  parameter int A_VS_POL = 1,
  parameter int B_H_ACT  = 640,
  parameter int B_H_FP   = 16,
  parameter int B_H_SYNC = 96,
  parameter int B_H_BP   = 48,
  parameter int B_V_ACT  = 480,
  parameter int B_V_FP   = 10,
  parameter int B_V_SYNC = 2,
  parameter int B_V_BP   = 33,
  parameter int B_HS_POL = 0,
  parameter int B_VS_POL = 0
) (
  input  wire logic    pclk,
  input  wire logic    rst,
  vga_timing_if.master vga
);

  // Segment boundaries, pre-folded to counter width so every compare is a
  // plain unsigned CW-bit compare against the shown counter value.
  localparam logic [CW-1:0] c_a_h_tot_m1 = CW'(A_H_ACT + A_H_FP + A_H_SYNC + A_H_BP - 1);
  localparam logic [CW-1:0] c_a_v_tot_m1 = CW'(A_V_ACT + A_V_FP + A_V_SYNC + A_V_BP - 1);
  localparam logic [CW-1:0] c_a_h_act    = CW'(A_H_ACT);
  localparam logic [CW-1:0] c_a_v_act    = CW'(A_V_ACT);
  localparam logic [CW-1:0] c_a_hs_first = CW'(A_H_ACT + A_H_FP);
  localparam logic [CW-1:0] c_a_hs_last  = CW'(A_H_ACT + A_H_FP + A_H_SYNC - 1);
  localparam logic [CW-1:0] c_a_vs_first = CW'(A_V_ACT + A_V_FP);
  localparam logic [CW-1:0] c_a_vs_last  = CW'(A_V_ACT + A_V_FP + A_V_SYNC - 1);
  localparam logic          c_a_hs_pol   = (A_HS_POL != 0);
  localparam logic          c_a_vs_pol   = (A_VS_POL != 0);

  localparam logic [CW-1:0] c_b_h_tot_m1 = CW'(B_H_ACT + B_H_FP + B_H_SYNC + B_H_BP - 1);
  localparam logic [CW-1:0] c_b_v_tot_m1 = CW'(B_V_ACT + B_V_FP + B_V_SYNC + B_V_BP - 1);
  localparam logic [CW-1:0] c_b_h_act    = CW'(B_H_ACT);
  localparam logic [CW-1:0] c_b_v_act    = CW'(B_V_ACT);
  localparam logic [CW-1:0] c_b_hs_first = CW'(B_H_ACT + B_H_FP);
  localparam logic [CW-1:0] c_b_hs_last  = CW'(B_H_ACT + B_H_FP + B_H_SYNC - 1);
  localparam logic [CW-1:0] c_b_vs_first = CW'(B_V_ACT + B_V_FP);
  localparam logic [CW-1:0] c_b_vs_last  = CW'(B_V_ACT + B_V_FP + B_V_SYNC - 1);
  localparam logic          c_b_hs_pol   = (B_HS_POL != 0);
  localparam logic          c_b_vs_pol   = (B_VS_POL != 0);

  logic [CW-1:0]  hcount_q, hcount_d;
  logic [CW-1:0]  vcount_q, vcount_d;
  logic           mode_q, mode_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           hblnk_q, hblnk_d;
  logic           vblnk_q, vblnk_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;

  logic [CW-1:0]  w_h_tot_m1;
  logic [CW-1:0]  w_v_tot_m1;
  logic           w_h_last;
  logic           w_v_last;

  logic [CW-1:0]  w_h_act;
  logic [CW-1:0]  w_v_act;
  logic [CW-1:0]  w_hs_first;
  logic [CW-1:0]  w_hs_last;
  logic [CW-1:0]  w_vs_first;
  logic [CW-1:0]  w_vs_last;
  logic           w_hs_pol;
  logic           w_vs_pol;
  logic           w_hs_on;
  logic           w_vs_on;

  // Raster advance: totals come from the mode currently in effect.
  always_comb begin
    w_h_tot_m1    = mode_q ? c_b_h_tot_m1 : c_a_h_tot_m1;
    w_v_tot_m1    = mode_q ? c_b_v_tot_m1 : c_a_v_tot_m1;
    w_h_last      = (hcount_q == w_h_tot_m1);
    w_v_last      = (vcount_q == w_v_tot_m1);

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    mode_d        = mode_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (vga.ce) begin
      if (w_h_last) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (w_v_last) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          mode_d        = vga.mode_sel;
          frame_cnt_d   = frame_cnt_q + FCW'(1);
        end else begin
          vcount_d = vcount_q + CW'(1);
        end
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
  end

  // Decode from the next counter values and next mode so the registered
  // flags line up with the counters they are shown alongside, including
  // across a mode switch at the frame wrap.
  always_comb begin
    w_h_act    = mode_d ? c_b_h_act    : c_a_h_act;
    w_v_act    = mode_d ? c_b_v_act    : c_a_v_act;
    w_hs_first = mode_d ? c_b_hs_first : c_a_hs_first;
    w_hs_last  = mode_d ? c_b_hs_last  : c_a_hs_last;
    w_vs_first = mode_d ? c_b_vs_first : c_a_vs_first;
    w_vs_last  = mode_d ? c_b_vs_last  : c_a_vs_last;
    w_hs_pol   = mode_d ? c_b_hs_pol   : c_a_hs_pol;
    w_vs_pol   = mode_d ? c_b_vs_pol   : c_a_vs_pol;

    w_hs_on    = (hcount_d >= w_hs_first) && (hcount_d <= w_hs_last);
    w_vs_on    = (vcount_d >= w_vs_first) && (vcount_d <= w_vs_last);

    hblnk_d    = (hcount_d >= w_h_act);
    vblnk_d    = (vcount_d >= w_v_act);
    hsync_d    = w_hs_on ? w_hs_pol : ~w_hs_pol;
    vsync_d    = w_vs_on ? w_vs_pol : ~w_vs_pol;
    de_d       = ~hblnk_d & ~vblnk_d;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      mode_q        <= 1'b0;
      frame_cnt_q   <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~c_a_hs_pol;
      vsync_q       <= ~c_a_vs_pol;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.hblnk       = hblnk_q;
  assign vga.vblnk       = vblnk_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.mode_act    = mode_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Self-checking bench for vga_timing_gen using shrunk raster modes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int CW  = 8;
  localparam int FCW = 2;
  localparam int A_H_ACT = 16, A_H_FP = 2, A_H_SYNC = 3, A_H_BP = 3;
  localparam int A_V_ACT = 10, A_V_FP = 1, A_V_SYNC = 2, A_V_BP = 3;
  localparam int A_HS_POL = 1, A_VS_POL = 1;
  localparam int B_H_ACT = 12, B_H_FP = 1, B_H_SYNC = 2, B_H_BP = 2;
  localparam int B_V_ACT = 8,  B_V_FP = 2, B_V_SYNC = 1, B_V_BP = 2;
  localparam int B_HS_POL = 0, B_VS_POL = 0;

  localparam int A_HT = A_H_ACT + A_H_FP + A_H_SYNC + A_H_BP;
  localparam int A_VT = A_V_ACT + A_V_FP + A_V_SYNC + A_V_BP;
  localparam int B_HT = B_H_ACT + B_H_FP + B_H_SYNC + B_H_BP;
  localparam int B_VT = B_V_ACT + B_V_FP + B_V_SYNC + B_V_BP;
  localparam int A_FRAME = A_HT * A_VT;
  localparam int B_FRAME = B_HT * B_VT;
  localparam int VW = 2 * CW + 8 + FCW;

  logic pclk = 1'b0;
  logic rst  = 1'b0;

  vga_timing_if #(.CW(CW), .FCW(FCW)) vga ();

  vga_timing_gen #(
    .CW(CW), .FCW(FCW),
    .A_H_ACT(A_H_ACT), .A_H_FP(A_H_FP), .A_H_SYNC(A_H_SYNC), .A_H_BP(A_H_BP),
    .A_V_ACT(A_V_ACT), .A_V_FP(A_V_FP), .A_V_SYNC(A_V_SYNC), .A_V_BP(A_V_BP),
    .A_HS_POL(A_HS_POL), .A_VS_POL(A_VS_POL),
    .B_H_ACT(B_H_ACT), .B_H_FP(B_H_FP), .B_H_SYNC(B_H_SYNC), .B_H_BP(B_H_BP),
    .B_V_ACT(B_V_ACT), .B_V_FP(B_V_FP), .B_V_SYNC(B_V_SYNC), .B_V_BP(B_V_BP),
    .B_HS_POL(B_HS_POL), .B_VS_POL(B_VS_POL)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .vga (vga)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: linear pixel index within the frame plus frame-level state.
  int m_p;
  bit m_mode;
  int m_fcnt;
  bit m_ls;
  bit m_fs;

  logic [VW-1:0] rst_vec;

  function automatic void model_reset();
    m_p = 0; m_mode = 1'b0; m_fcnt = 0; m_ls = 1'b0; m_fs = 1'b0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int ht, ha, va, hs0, hs1, vs0, vs1, h, v;
    bit hpol, vpol, hb, vb, hs, vs;
    if (m_mode) begin
      ht = B_HT; ha = B_H_ACT; va = B_V_ACT;
      hs0 = B_H_ACT + B_H_FP; hs1 = hs0 + B_H_SYNC;
      vs0 = B_V_ACT + B_V_FP; vs1 = vs0 + B_V_SYNC;
      hpol = (B_HS_POL != 0); vpol = (B_VS_POL != 0);
    end else begin
      ht = A_HT; ha = A_H_ACT; va = A_V_ACT;
      hs0 = A_H_ACT + A_H_FP; hs1 = hs0 + A_H_SYNC;
      vs0 = A_V_ACT + A_V_FP; vs1 = vs0 + A_V_SYNC;
      hpol = (A_HS_POL != 0); vpol = (A_VS_POL != 0);
    end
    h  = m_p % ht;
    v  = m_p / ht;
    hb = (h >= ha);
    vb = (v >= va);
    hs = (h >= hs0 && h < hs1) ? hpol : !hpol;
    vs = (v >= vs0 && v < vs1) ? vpol : !vpol;
    return {CW'(h), CW'(v), hb, vb, hs, vs, (!hb && !vb), m_ls, m_fs, m_mode, FCW'(m_fcnt)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {vga.hcount, vga.vcount, vga.hblnk, vga.vblnk, vga.hsync, vga.vsync,
            vga.de, vga.line_start, vga.frame_start, vga.mode_act, vga.frame_cnt};
  endfunction

  // Drive ce, take one pclk edge, advance the model, settle 1 time unit.
  task automatic tick(input bit ce_v);
    int ht, tot;
    vga.ce = ce_v;
    @(posedge pclk);
    ht  = m_mode ? B_HT : A_HT;
    tot = m_mode ? B_FRAME : A_FRAME;
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (ce_v) begin
      m_p++;
      if (m_p % ht == 0) m_ls = 1'b1;
      if (m_p == tot) begin
        m_p    = 0;
        m_mode = vga.mode_sel;
        m_fcnt = (m_fcnt + 1) % (1 << FCW);
        m_fs   = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    vga.ce = 1'b1;
    vga.mode_sel = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++;
    if (obs_vec() !== rst_vec) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", obs_vec(), rst_vec);
    end
    n_cmp++;
    if ({vga.hsync, vga.vsync} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_sync_mode_a: got %b want 00", {vga.hsync, vga.vsync});
    end
    rst = 1'b1;
    model_reset();
    tick(1'b1);
    n_cmp++;
    if (vga.hcount !== CW'(1) || vga.vcount !== CW'(0) || vga.line_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got h=%0d v=%0d ls=%b want h=1 v=0 ls=0",
               vga.hcount, vga.vcount, vga.line_start);
    end
  endtask

  task automatic test_mode_a_frame();
    int cyc, fs_cnt, hs_l0, hb_l0, vs_lines, vb_lines, hs_first;
    logic [VW-1:0] e;
    cyc = 0; fs_cnt = 0; hs_l0 = 0; hb_l0 = 0; vs_lines = 0; vb_lines = 0; hs_first = -1;
    vga.mode_sel = 1'b0;
    while (fs_cnt == 0 && cyc < 2 * A_FRAME) begin
      tick(1'b1);
      cyc++;
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL mode_a_frame cyc %0d: got %h want %h", cyc, obs_vec(), e);
      end
      if (vga.frame_start === 1'b1) fs_cnt++;
      if (vga.vcount == 0 && vga.hsync === 1'b1) begin
        hs_l0++;
        if (hs_first < 0) hs_first = int'(vga.hcount);
      end
      if (vga.vcount == 0 && vga.hblnk === 1'b1) hb_l0++;
      if (vga.hcount == 0 && vga.vsync === 1'b1) vs_lines++;
      if (vga.hcount == 0 && vga.vblnk === 1'b1) vb_lines++;
    end
    n_cmp++;
    if (cyc !== A_FRAME - 1 || fs_cnt !== 1) begin
      n_bad++;
      $display("FAIL mode_a_period: got %0d cycles %0d strobes want %0d cycles 1 strobe",
               cyc, fs_cnt, A_FRAME - 1);
    end
    n_cmp++;
    if (hs_l0 !== A_H_SYNC || hs_first !== A_H_ACT + A_H_FP) begin
      n_bad++;
      $display("FAIL mode_a_hsync: got %0d wide from %0d want %0d from %0d",
               hs_l0, hs_first, A_H_SYNC, A_H_ACT + A_H_FP);
    end
    n_cmp++;
    if (hb_l0 !== A_HT - A_H_ACT) begin
      n_bad++;
      $display("FAIL mode_a_hblnk: got %0d want %0d", hb_l0, A_HT - A_H_ACT);
    end
    n_cmp++;
    if (vs_lines !== A_V_SYNC || vb_lines !== A_VT - A_V_ACT) begin
      n_bad++;
      $display("FAIL mode_a_vert: got vs=%0d vb=%0d want vs=%0d vb=%0d",
               vs_lines, vb_lines, A_V_SYNC, A_VT - A_V_ACT);
    end
    n_cmp++;
    if (vga.frame_cnt !== FCW'(1)) begin
      n_bad++;
      $display("FAIL mode_a_frame_cnt: got %0d want 1", vga.frame_cnt);
    end
  endtask

  task automatic test_ce_gating();
    int en_cnt, ls_cnt, cyc;
    bit ce_v;
    logic [VW-1:0] e;
    en_cnt = 0; ls_cnt = 0; cyc = 0;
    while (ls_cnt < 2 && cyc < 8 * A_HT) begin
      ce_v = (cyc < A_HT) ? cyc[0] == 1'b0 : 1'($urandom_range(0, 1));
      tick(ce_v);
      cyc++;
      if (ce_v) en_cnt++;
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL ce_gating cyc %0d ce %b: got %h want %h", cyc, ce_v, obs_vec(), e);
      end
      if (vga.line_start === 1'b1) ls_cnt++;
    end
    n_cmp++;
    if (en_cnt !== 2 * A_HT) begin
      n_bad++;
      $display("FAIL ce_two_lines: got %0d enabled cycles want %0d", en_cnt, 2 * A_HT);
    end
    tick(1'b0);
    n_cmp++;
    if (vga.line_start !== 1'b0 || vga.frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL ce_low_strobes: got ls=%b fs=%b want 0 0", vga.line_start, vga.frame_start);
    end
  endtask

  task automatic test_mode_switch();
    int cyc, hs_l0, vs_lines, hmax;
    logic [VW-1:0] e;
    cyc = 0;
    while (!(vga.vcount == CW'(A_V_ACT / 2) && vga.hcount == CW'(5)) && cyc < 2 * A_FRAME) begin
      tick(1'b1);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 2 * A_FRAME) begin
      n_bad++;
      $display("FAIL switch_reach_point: got timeout want position (5,%0d)", A_V_ACT / 2);
    end
    vga.mode_sel = 1'b1;
    cyc = 0;
    m_fs = 1'b0;
    while (!m_fs && cyc < 2 * A_FRAME) begin
      tick(1'b1);
      cyc++;
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL switch_tail cyc %0d: got %h want %h", cyc, obs_vec(), e);
      end
      if (!m_fs && vga.mode_act !== 1'b0) begin
        n_bad++;
        $display("FAIL switch_early: got mode_act=%b want 0", vga.mode_act);
      end
    end
    n_cmp++;
    if (vga.mode_act !== 1'b1 || vga.hcount !== CW'(0) || vga.vcount !== CW'(0)) begin
      n_bad++;
      $display("FAIL switch_at_wrap: got mode=%b h=%0d v=%0d want 1 0 0",
               vga.mode_act, vga.hcount, vga.vcount);
    end
    cyc = 0; hs_l0 = 0; vs_lines = 0; hmax = 0;
    m_fs = 1'b0;
    while (!m_fs && cyc < 2 * B_FRAME) begin
      tick(1'b1);
      cyc++;
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL mode_b_frame cyc %0d: got %h want %h", cyc, obs_vec(), e);
      end
      if (int'(vga.hcount) > hmax) hmax = int'(vga.hcount);
      if (vga.vcount == 0 && vga.hsync === 1'b0) hs_l0++;
      if (vga.hcount == 0 && vga.vsync === 1'b0) vs_lines++;
    end
    n_cmp++;
    if (cyc !== B_FRAME || hmax !== B_HT - 1) begin
      n_bad++;
      $display("FAIL mode_b_period: got %0d cycles hmax %0d want %0d hmax %0d",
               cyc, hmax, B_FRAME, B_HT - 1);
    end
    n_cmp++;
    if (hs_l0 !== B_H_SYNC || vs_lines !== B_V_SYNC) begin
      n_bad++;
      $display("FAIL mode_b_sync_low: got hs=%0d vs=%0d want hs=%0d vs=%0d",
               hs_l0, vs_lines, B_H_SYNC, B_V_SYNC);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n;
    logic [VW-1:0] e;
    n = int'($urandom_range(50, 150));
    for (int i = 0; i < n; i++) tick(1'b1);
    vga.mode_sel = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== rst_vec) begin
      n_bad++;
      $display("FAIL reset_mid_immediate: got %h want %h", obs_vec(), rst_vec);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk);
      #1;
      n_cmp++;
      if (obs_vec() !== rst_vec) begin
        n_bad++;
        $display("FAIL reset_mid_hold %0d: got %h want %h", i, obs_vec(), rst_vec);
      end
    end
    rst = 1'b1;
    model_reset();
    cyc = 0;
    while (!m_fs && cyc < 2 * A_FRAME) begin
      tick(1'b1);
      cyc++;
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL reset_mid_restart cyc %0d: got %h want %h", cyc, obs_vec(), e);
      end
    end
    n_cmp++;
    if (cyc !== A_FRAME) begin
      n_bad++;
      $display("FAIL reset_mid_first_fs: got %0d cycles want %0d", cyc, A_FRAME);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    int cyc, k;
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
    vga.mode_sel = 1'b0;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 5 * A_FRAME) begin
      tick(1'b1);
      cyc++;
      if (vga.frame_start === 1'b1) begin
        n_cmp++;
        if (vga.frame_cnt !== FCW'((k + 1) % 4)) begin
          n_bad++;
          $display("FAIL frame_cnt_wrap frame %0d: got %0d want %0d", k, vga.frame_cnt, (k + 1) % 4);
        end
        k++;
      end
    end
    n_cmp++;
    if (k !== 4) begin
      n_bad++;
      $display("FAIL frame_cnt_frames: got %0d frames want 4", k);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) vga.mode_sel = ~vga.mode_sel;
      tick($urandom_range(0, 3) != 0);
      e = exp_vec();
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), e);
      end
    end
  endtask

  initial begin
    rst_vec = {{CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, (A_HS_POL == 0), (A_VS_POL == 0),
               1'b1, 1'b0, 1'b0, 1'b0, {FCW{1'b0}}};
    vga.ce = 1'b0;
    vga.mode_sel = 1'b0;
    model_reset();
    test_reset();
    test_mode_a_frame();
    test_ce_gating();
    test_mode_switch();
    test_reset_mid();
    test_frame_cnt_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
